// File: rtl/simple_uart_rx_ctrl.sv
// rtl/simple_uart_rx_ctrl.sv - RX UART sequencer, receive FIFO and byte-wide register port
module simple_uart_rx_ctrl #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_din,
    input  logic       rx_valid,
    output logic       rx_cfg_wr,
    output logic       rx_cfg_d,
    output logic       rx_cfg_accept,
    input  logic [1:0] bus_addr,
    input  logic       bus_rd,
    input  logic       bus_wr,
    input  logic [7:0] bus_wdata,
    output logic [7:0] bus_rdata,
    output logic       o_irq
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_CFG} state_t;

    state_t        state_q;
    logic [7:0]    hold_q;
    logic          shadow_q, desired_q, overrun_q, cfg_wr_q, irq_q;
    logic [7:0]    rdata_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d, level;
    logic [7:0]    mem_q [DEPTH];

    logic          empty, full, cfg_pending, ctrl_wr, flush, ovr_clr;
    logic          push_req, pop, push_ok, ovr_set, overrun_d;
    logic [7:0]    rdata_d;
    logic [15:0]   level_ext;
    logic          unused_wdata;

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                         (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign level       = wr_ptr_q - rd_ptr_q;
    assign level_ext   = 16'(level);
    assign cfg_pending = (desired_q != shadow_q);
    assign unused_wdata = ^bus_wdata[7:3];

    assign ctrl_wr  = bus_wr && (bus_addr == 2'd2);
    assign flush    = ctrl_wr && bus_wdata[1];
    assign ovr_clr  = ctrl_wr && bus_wdata[2];
    assign push_req = (state_q == S_ACCEPT);
    assign pop      = bus_rd && (bus_addr == 2'd0) && !empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop) && !flush;
    assign ovr_set  = push_req && full && !pop && !flush;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        overrun_d = ovr_set | (overrun_q & ~ovr_clr);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_comb begin
        rdata_d = 8'h00;
        case (bus_addr)
            2'd0:    rdata_d = empty ? 8'h00 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
            2'd1:    rdata_d = {3'b000, cfg_pending, shadow_q & rx_valid,
                                overrun_q, full, ~empty};
            2'd2:    rdata_d = {7'b0, desired_q};
            default: rdata_d = level_ext[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= hold_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= 8'h00;
            desired_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            overrun_q <= overrun_d;
            irq_q     <= (wr_ptr_d != rd_ptr_d) | overrun_d;
            if (bus_rd)  rdata_q   <= rdata_d;
            if (ctrl_wr) desired_q <= bus_wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            hold_q   <= 8'h00;
            shadow_q <= 1'b0;
            cfg_wr_q <= 1'b0;
        end else begin
            cfg_wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // In measure mode rx_valid flags a measurement, not a character.
                    if (rx_valid && !shadow_q) begin
                        hold_q   <= rx_din;
                        state_q  <= S_ACCEPT;
                        cfg_wr_q <= 1'b1;
                    end else if (cfg_pending) begin
                        state_q  <= S_CFG;
                        cfg_wr_q <= 1'b1;
                    end
                end
                S_ACCEPT: state_q <= S_IDLE;
                S_CFG: begin
                    shadow_q <= desired_q;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_cfg_wr     = cfg_wr_q;
    assign rx_cfg_accept = cfg_wr_q;
    assign rx_cfg_d      = (state_q == S_CFG) ? desired_q : shadow_q;
    assign bus_rdata     = rdata_q;
    assign o_irq         = irq_q;
endmodule

// File: tb/tb_simple_uart_rx_ctrl.sv
// tb/tb_simple_uart_rx_ctrl.sv - self-checking bench for simple_uart_rx_ctrl
module tb_simple_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_din;
    logic       rx_valid;
    logic       rx_cfg_wr, rx_cfg_d, rx_cfg_accept;
    logic [1:0] bus_addr;
    logic       bus_rd, bus_wr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       o_irq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       rd;
        logic       wr;
        logic [1:0] addr;
        logic [7:0] wdata;
        logic       chk;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[13];

    simple_uart_rx_ctrl #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .rx_din(rx_din), .rx_valid(rx_valid),
        .rx_cfg_wr(rx_cfg_wr), .rx_cfg_d(rx_cfg_d), .rx_cfg_accept(rx_cfg_accept),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [7:0] d);
        bus_rd = rd; bus_wr = wr; bus_addr = a; bus_wdata = d;
        step();
        bus_rd = 1'b0; bus_wr = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [1:0] a, input logic [7:0] exp);
        bus(1'b1, 1'b0, a, 8'h00);
        check(name, bus_rdata, exp);
    endtask

    task automatic rd_data_sb(input string name);
        logic [7:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 8'h00;
        rd_check(name, 2'd0, e);
    endtask

    // UART model: hold rx_valid until the accept pulse, then clear it.
    task automatic deliver(input logic [7:0] b);
        int lat;
        rx_din = b; rx_valid = 1'b1; lat = 0;
        do begin
            step();
            lat++;
        end while (!rx_cfg_accept && lat < 8);
        check($sformatf("accept_latency_%02h", b), lat, 1);
        check($sformatf("accept_cfg_d_%02h", b), rx_cfg_d, 0);
        rx_valid = 1'b0;
        step();
        if (sb.size() < 16) sb.push_back(b);
    endtask

    initial begin
        logic [2:0] seen;
        logic       any_acc;
        reset = 1'b1; rx_din = 8'h00; rx_valid = 1'b0;
        bus_addr = 2'd0; bus_rd = 1'b0; bus_wr = 1'b0; bus_wdata = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset_outputs", {rx_cfg_wr, rx_cfg_d, rx_cfg_accept, bus_rdata, o_irq}, 0);

        vecs[0]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 2'd0, 8'hFF, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b1, 8'h00};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 8'h01, 1'b1, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 8'h01};
        vecs[8]  = '{1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 8'h10};
        vecs[10] = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 8'h10};
        vecs[11] = '{1'b1, 1'b0, 2'd1, 8'h00, 1'b1, 8'h00};
        vecs[12] = '{1'b1, 1'b0, 2'd2, 8'h00, 1'b1, 8'h00};
        for (int i = 0; i < 13; i++) begin
            bus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk) check($sformatf("vec%0d", i), bus_rdata, vecs[i].exp);
        end

        deliver(8'h55);
        check("t1_irq_high", o_irq, 1);
        rd_check("t1_level1", 2'd3, 8'h01);
        rd_data_sb("t1_data");
        rd_check("t1_level0", 2'd3, 8'h00);
        check("t1_irq_low", o_irq, 0);

        for (int i = 0; i <= 16; i++) deliver(8'(i));
        rd_check("t2_status_ovr", 2'd1, 8'h07);
        check("t2_irq", o_irq, 1);
        for (int i = 0; i < 16; i++) rd_data_sb($sformatf("t2_data%0d", i));
        rd_check("t2_status_empty", 2'd1, 8'h04);
        bus(1'b0, 1'b1, 2'd2, 8'h04);
        rd_check("t2_status_clr", 2'd1, 8'h00);
        check("t2_irq_clr", o_irq, 0);

        for (int i = 0; i < 16; i++) deliver(8'(8'h20 + i));
        rx_din = 8'h30; rx_valid = 1'b1;
        step();
        check("t3_accept", rx_cfg_accept, 1);
        rx_valid = 1'b0; bus_rd = 1'b1; bus_addr = 2'd0;
        step();
        bus_rd = 1'b0;
        check("t3_pop_push_data", bus_rdata, sb.pop_front());
        sb.push_back(8'h30);
        rd_check("t3_status", 2'd1, 8'h03);
        rd_check("t3_level", 2'd3, 8'h10);
        for (int i = 0; i < 16; i++) rd_data_sb($sformatf("t3_data%0d", i));

        rx_din = 8'hA5; rx_valid = 1'b1;
        bus_wr = 1'b1; bus_addr = 2'd2; bus_wdata = 8'h01;
        step();
        bus_wr = 1'b0; rx_valid = 1'b0;
        seen = {rx_cfg_wr, rx_cfg_accept, rx_cfg_d};
        check("t4_accept_first", seen, 3'b110);
        step();
        seen = {rx_cfg_wr, rx_cfg_accept, rx_cfg_d};
        check("t4_gap", seen, 3'b000);
        step();
        seen = {rx_cfg_wr, rx_cfg_accept, rx_cfg_d};
        check("t4_cfg", seen, 3'b111);
        step();
        seen = {rx_cfg_wr, rx_cfg_accept, rx_cfg_d};
        check("t4_after_cfg", seen, 3'b001);
        sb.push_back(8'hA5);
        rx_din = 8'h77; rx_valid = 1'b1; any_acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            any_acc |= rx_cfg_accept;
        end
        check("t4_measure_no_accept", any_acc, 0);
        rd_check("t4_status", 2'd1, 8'h09);
        rd_check("t4_level", 2'd3, 8'h01);
        rx_valid = 1'b0;
        rd_data_sb("t4_data");
        bus(1'b0, 1'b1, 2'd2, 8'h00);
        step(); step();
        check("t4_cfg_d_back", rx_cfg_d, 0);
        rd_check("t4_status_back", 2'd1, 8'h00);

        for (int i = 0; i < 5; i++) deliver(8'(8'h40 + i));
        rd_check("t5_level5", 2'd3, 8'h05);
        rx_din = 8'h45; rx_valid = 1'b1;
        step();
        check("t5_accept", rx_cfg_accept, 1);
        rx_valid = 1'b0; bus_wr = 1'b1; bus_addr = 2'd2; bus_wdata = 8'h02;
        step();
        bus_wr = 1'b0;
        sb.delete();
        rd_check("t5_level0", 2'd3, 8'h00);
        rd_data_sb("t5_data_empty");
        rd_check("t5_status", 2'd1, 8'h00);

        deliver(8'h66);
        rd_check("t6_level1", 2'd3, 8'h01);
        rx_din = 8'h99; rx_valid = 1'b1;
        step();
        check("t6_accept", rx_cfg_accept, 1);
        reset = 1'b1; rx_valid = 1'b0;
        step();
        check("t6_reset_outputs", {rx_cfg_wr, rx_cfg_d, rx_cfg_accept, bus_rdata, o_irq}, 0);
        reset = 1'b0;
        sb.delete();
        step();
        check("t6_no_cfg_wr", rx_cfg_wr, 0);
        rd_check("t6_level0", 2'd3, 8'h00);
        rd_check("t6_status", 2'd1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
